wb_m_bridge_adapter: RTL

//  Master-side feeder for the two-FF 4-phase clock-domain bridge (bridge_top).
//  - Accepts single Wishbone classic cycles in the clk_m domain.
//  - Serialises each cycle into bridge words on sdata_m/vi_m:
//    - read: header word only;
//    - write: header word, then data word.
//  - Waits for snt_m, and for vo_m/rdata_m on reads, then terminates the cycle with wb_ack_o or wb_err_o.

---
 rtl/wb_m_bridge_adapter_pkg.sv | 20 ++
 rtl/wb_m_bridge_adapter_if.sv | 42 ++++
 rtl/wb_m_bridge_adapter_timer.sv | 29 ++
 rtl/wb_m_bridge_adapter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/wb_m_bridge_adapter_pkg.sv
// Shared constants and state encoding for the Wishbone-to-bridge master feeder.
// Header layout: we on the MSB, byte selects below it, address in the low bits.
package wb_m_bridge_adapter_pkg;

  localparam int DATA_MSB = 31;
  localparam int HDR_WE = DATA_MSB;
  localparam int HDR_SEL_MSB = DATA_MSB - 1;
  localparam int HDR_SEL_LSB = DATA_MSB - 4;
  localparam int HDR_ADR_MSB = 23;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HWAIT = 3'd1,
    DWAIT = 3'd2,
    RWAIT = 3'd3,
    ACK   = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/wb_m_bridge_adapter_if.sv
// Wishbone slave-side signals plus the master-domain bridge word handshake.
// slave = adapter view, master = requester/bridge-model view.
interface wb_m_bridge_adapter_if
  import wb_m_bridge_adapter_pkg::*;
#(
  parameter int DW = DATA_MSB + 1,
  parameter int AW = 24,
  parameter int SW = 4
);

  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [SW-1:0] wb_sel_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic [DW-1:0] sdata_m;
  logic          vi_m;
  logic          snt_m;
  logic          vo_m;
  logic [DW-1:0] rdata_m;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    input  snt_m, vo_m, rdata_m,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output sdata_m, vi_m
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    output snt_m, vo_m, rdata_m,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  sdata_m, vi_m
  );

endinterface

// File: rtl/wb_m_bridge_adapter_timer.sv
// Wait-state watchdog: counts cycles since clear while enabled.
// expired flags the last permitted wait cycle; TIMEOUT=0 never expires.
module bridge_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/wb_m_bridge_adapter.sv
// Serialises Wishbone classic cycles into bridge words and terminates
// them with ack on completion or err on bridge timeout.
module wb_m_bridge_adapter
  import wb_m_bridge_adapter_pkg::*;
#(
  parameter int DW = DATA_MSB + 1,
  parameter int AW = 24,
  parameter int SW = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk_m,
  input logic rst_m,
  wb_m_bridge_adapter_if.slave bus
);

  state_t        state;
  logic          we_q;
  logic          abort_q;
  logic [DW-1:0] dat_q;
  logic          waiting;
  logic          event_hit;
  logic          expired;
  logic          quit;

  function automatic logic [DW-1:0] hdr(
    input logic          we,
    input logic [SW-1:0] sel,
    input logic [AW-1:0] adr
  );
    logic [DW-1:0] h;
    h = '0;
    h[DW-1] = we;
    h[DW-2 -: SW] = sel;
    h[AW-1:0] = adr;
    return h;
  endfunction

  assign waiting = state inside {HWAIT, DWAIT, RWAIT};

  always_comb begin
    event_hit = 1'b0;
    unique case (state)
      HWAIT, DWAIT: event_hit = bus.snt_m;
      RWAIT:        event_hit = bus.vo_m;
      default:      event_hit = 1'b0;
    endcase
  end

  // A dropped cyc only suppresses termination; the bridge exchange runs out.
  assign quit = abort_q | ~bus.wb_cyc_i;

  bridge_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk_m),
    .rst    (rst_m),
    .clear  (~waiting | event_hit),
    .en     (waiting),
    .expired(expired)
  );

  always_ff @(posedge clk_m) begin
    if (rst_m) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      abort_q      <= 1'b0;
      dat_q        <= '0;
      bus.sdata_m  <= '0;
      bus.vi_m     <= 1'b0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_err_o <= 1'b0;
      bus.wb_dat_o <= '0;
    end else begin
      bus.vi_m     <= 1'b0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_err_o <= 1'b0;
      if (waiting) abort_q <= quit;
      unique case (state)
        IDLE: begin
          if (bus.wb_cyc_i && bus.wb_stb_i) begin
            we_q        <= bus.wb_we_i;
            dat_q       <= bus.wb_dat_i;
            abort_q     <= 1'b0;
            bus.sdata_m <= hdr(bus.wb_we_i, bus.wb_sel_i,
                               bus.wb_adr_i);
            bus.vi_m    <= 1'b1;
            state       <= HWAIT;
          end
        end
        HWAIT: begin
          if (bus.snt_m) begin
            if (we_q) begin
              bus.sdata_m <= dat_q;
              bus.vi_m    <= 1'b1;
              state       <= DWAIT;
            end else if (bus.vo_m) begin
              if (!quit) bus.wb_dat_o <= bus.rdata_m;
              bus.wb_ack_o <= ~quit;
              state        <= quit ? IDLE : ACK;
            end else begin
              state <= RWAIT;
            end
          end else if (expired) begin
            bus.wb_err_o <= ~quit;
            state        <= quit ? IDLE : ERR;
          end
        end
        DWAIT: begin
          if (bus.snt_m) begin
            bus.wb_ack_o <= ~quit;
            state        <= quit ? IDLE : ACK;
          end else if (expired) begin
            bus.wb_err_o <= ~quit;
            state        <= quit ? IDLE : ERR;
          end
        end
        RWAIT: begin
          if (bus.vo_m) begin
            if (!quit) bus.wb_dat_o <= bus.rdata_m;
            bus.wb_ack_o <= ~quit;
            state        <= quit ? IDLE : ACK;
          end else if (expired) begin
            bus.wb_err_o <= ~quit;
            state        <= quit ? IDLE : ERR;
          end
        end
        ACK, ERR: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
